// File: rtl/fpu_md_seq.sv
// fpu_md_seq: request sequencer for a float32 multiply/divide pair.
// Buffers requests in a FIFO and issues one operation at a time to the
// selected engine. It waits for that engine's completion or a timeout, then
// holds the response until the consumer takes it.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   in_valid_i / in_ready_o       request handshake
//   in_op_i, in_frm_i, in_a_i,
//   in_b_i, in_tag_i              request payload (op 0 = mul, 1 = div)
//   flush_i                       synchronous abort of queued and in-flight work
//   eng_a_o, eng_b_o, eng_frm_o   registered operands shared by both engines
//   mul_start_o, div_start_o      single-cycle engine start pulses
//   mul_*_i, div_*_i              engine completion, result, inexact flag
//   out_valid_o / out_ready_i     response handshake
//   out_result_o, out_nx_o,
//   out_err_o, out_tag_o, out_op_o response payload
//   occupancy_o                   queued entries, excluding the in-flight one
module fpu_md_seq #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_op_i,
    input  logic [2:0]               in_frm_i,
    input  logic [31:0]              in_a_i,
    input  logic [31:0]              in_b_i,
    input  logic [TAGW-1:0]          in_tag_i,
    input  logic                     flush_i,
    output logic [31:0]              eng_a_o,
    output logic [31:0]              eng_b_o,
    output logic [2:0]               eng_frm_o,
    output logic                     mul_start_o,
    output logic                     div_start_o,
    input  logic                     mul_done_i,
    input  logic [31:0]              mul_result_i,
    input  logic                     mul_nx_i,
    input  logic                     div_done_i,
    input  logic [31:0]              div_result_i,
    input  logic                     div_nx_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_result_o,
    output logic                     out_nx_o,
    output logic                     out_err_o,
    output logic [TAGW-1:0]          out_tag_o,
    output logic                     out_op_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned TOW  = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic            op;
        logic [2:0]      frm;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    req_t            mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [TOW-1:0]  tmo_q, tmo_d;
    logic            op_q, op_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [31:0]     eng_a_q, eng_a_d;
    logic [31:0]     eng_b_q, eng_b_d;
    logic [2:0]      eng_frm_q, eng_frm_d;
    logic            mul_start_q, mul_start_d;
    logic            div_start_q, div_start_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_result_q, out_result_d;
    logic            out_nx_q, out_nx_d;
    logic            out_err_q, out_err_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic            out_op_q, out_op_d;

    logic            push_c;
    logic            pop_c;
    logic            done_sel_c;
    req_t            head_c;
    req_t            in_req_c;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign in_ready_o = (count_q != CNTW'(DEPTH));
    assign push_c     = in_valid_i & in_ready_o & ~flush_i;
    assign head_c     = mem_q[rd_ptr_q];
    assign done_sel_c = op_q ? div_done_i : mul_done_i;

    assign in_req_c = '{op: in_op_i, frm: in_frm_i, a: in_a_i, b: in_b_i, tag: in_tag_i};

    // FIFO storage: data only, pointers carry the reset state.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_req_c;
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTRW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTRW'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Sequencer next-state and registered outputs
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        op_d         = op_q;
        tag_d        = tag_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
        eng_frm_d    = eng_frm_q;
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_nx_d     = out_nx_q;
        out_err_d    = out_err_q;
        out_tag_d    = out_tag_q;
        out_op_d     = out_op_q;
        pop_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !flush_i) begin
                    pop_c       = 1'b1;
                    op_d        = head_c.op;
                    tag_d       = head_c.tag;
                    eng_a_d     = head_c.a;
                    eng_b_d     = head_c.b;
                    eng_frm_d   = head_c.frm;
                    // Pulse registers so the start is high exactly while in ISSUE.
                    mul_start_d = ~head_c.op;
                    div_start_d = head_c.op;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                out_tag_d = tag_q;
                out_op_d  = op_q;
                // Done is checked before the timeout so a coincident done wins.
                if (done_sel_c) begin
                    out_result_d = op_q ? div_result_i : mul_result_i;
                    out_nx_d     = op_q ? div_nx_i : mul_nx_i;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (tmo_q == TOW'(TIMEOUT - 1)) begin
                    out_result_d = QNAN;
                    out_nx_d     = 1'b0;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    tmo_d = tmo_q + TOW'(1);
                end
            end
            S_RESP: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            mul_start_d = 1'b0;
            div_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            op_q         <= 1'b0;
            tag_q        <= '0;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            eng_frm_q    <= '0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nx_q     <= 1'b0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            out_op_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            eng_a_q      <= eng_a_d;
            eng_b_q      <= eng_b_d;
            eng_frm_q    <= eng_frm_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_nx_q     <= out_nx_d;
            out_err_q    <= out_err_d;
            out_tag_q    <= out_tag_d;
            out_op_q     <= out_op_d;
        end
    end

    // A flush arriving during ISSUE suppresses the already-registered pulse.
    assign mul_start_o  = mul_start_q & ~flush_i;
    assign div_start_o  = div_start_q & ~flush_i;
    assign eng_a_o      = eng_a_q;
    assign eng_b_o      = eng_b_q;
    assign eng_frm_o    = eng_frm_q;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_nx_o     = out_nx_q;
    assign out_err_o    = out_err_q;
    assign out_tag_o    = out_tag_q;
    assign out_op_o     = out_op_q;
    assign occupancy_o  = count_q;

endmodule

// File: tb/tb_fpu_md_seq.sv
// Testbench for fpu_md_seq: engine models, scoreboard monitor, directed and random traffic.
module tb_fpu_md_seq;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAGW    = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned OCCW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_op = 1'b0;
    logic [2:0]      in_frm = '0;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            flush = 1'b0;
    logic [31:0]     eng_a, eng_b;
    logic [2:0]      eng_frm;
    logic            mul_start, div_start;
    logic            mul_done = 1'b0, div_done = 1'b0;
    logic [31:0]     mul_result = '0, div_result = '0;
    logic            mul_nx = 1'b0, div_nx = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    logic            out_nx, out_err;
    logic [TAGW-1:0] out_tag;
    logic            out_op;
    logic [OCCW-1:0] occupancy;

    fpu_md_seq #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_op_i(in_op), .in_frm_i(in_frm), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .flush_i(flush),
        .eng_a_o(eng_a), .eng_b_o(eng_b), .eng_frm_o(eng_frm),
        .mul_start_o(mul_start), .div_start_o(div_start),
        .mul_done_i(mul_done), .mul_result_i(mul_result), .mul_nx_i(mul_nx),
        .div_done_i(div_done), .div_result_i(div_result), .div_nx_i(div_nx),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_nx_o(out_nx), .out_err_o(out_err),
        .out_tag_o(out_tag), .out_op_o(out_op),
        .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    // Request plus the behaviour the engine model will show for it.
    typedef struct {
        bit            op;
        bit [2:0]      frm;
        bit [31:0]     a;
        bit [31:0]     b;
        bit [TAGW-1:0] tag;
        int            lat;
        bit            never;
        bit [31:0]     res;
        bit            nx;
    } req_t;

    req_t sb_q[$];
    req_t eng_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stray_en = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the engine answer if it arrives within TIMEOUT WAIT cycles, else the abort response.
    function automatic logic [38:0] model(input req_t r);
        if (r.never || r.lat > int'(TIMEOUT))
            return {32'h7FC0_0000, 1'b0, 1'b1, r.tag, r.op};
        return {r.res, r.nx, 1'b0, r.tag, r.op};
    endfunction

    function automatic req_t mk(input bit op, input bit [TAGW-1:0] tag, input int lat,
                                input bit never);
        req_t r;
        r.op = op; r.tag = tag; r.lat = lat; r.never = never;
        r.frm = 3'($urandom_range(0, 4));
        r.a = $urandom; r.b = $urandom; r.res = $urandom; r.nx = 1'($urandom);
        return r;
    endfunction

    // Scoreboard monitor: a response retires at the next edge when valid and ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 72'({out_result, out_tag}), 72'h0 - 72'd1);
            end else begin
                req_t r;
                r = sb_q.pop_front();
                chk($sformatf("resp_tag%0d", r.tag),
                    72'({out_result, out_nx, out_err, out_tag, out_op}), 72'(model(r)));
            end
        end
    end

    // Engine models for both units, with optional stray completions from the idle unit.
    int mcnt = 0, dcnt = 0;
    bit [31:0] mres, dres;
    bit mnx, dnx;
    bit cur_op = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = 0; dcnt = 0; mul_done = 1'b0; div_done = 1'b0;
        end else begin
            mul_done = 1'b0;
            div_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin mul_done = 1'b1; mul_result = mres; mul_nx = mnx; end
            end
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin div_done = 1'b1; div_result = dres; div_nx = dnx; end
            end
            if (flush)
                chk("start_during_flush", 72'({mul_start, div_start}), 72'd0);
            if (mul_start || div_start) begin
                if (eng_q.size() == 0) begin
                    chk("unexpected_start", 72'({mul_start, div_start}), 72'd0);
                end else begin
                    req_t r;
                    r = eng_q.pop_front();
                    chk("start_sel", 72'({mul_start, div_start}), r.op ? 72'd1 : 72'd2);
                    chk("eng_operands", 72'({eng_a, eng_b, eng_frm}), 72'({r.a, r.b, r.frm}));
                    cur_op = r.op;
                    if (!r.never) begin
                        if (r.op) begin dcnt = r.lat; dres = r.res; dnx = r.nx; end
                        else      begin mcnt = r.lat; mres = r.res; mnx = r.nx; end
                    end
                end
            end
            if (stray_en && $urandom_range(0, 2) == 0) begin
                if (cur_op && mcnt == 0) begin
                    mul_done = 1'b1; mul_result = $urandom; mul_nx = 1'b1;
                end else if (!cur_op && dcnt == 0) begin
                    div_done = 1'b1; div_result = $urandom; div_nx = 1'b1;
                end
            end
        end
    end

    // Random consumer backpressure, changed just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Offer one request from a negedge; returns at a negedge with in_valid low.
    task automatic push(input req_t r, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        in_valid = 1'b1; in_op = r.op; in_frm = r.frm; in_a = r.a; in_b = r.b; in_tag = r.tag;
        while (!ok && n < budget) begin
            if (in_ready) begin
                sb_q.push_back(r);
                eng_q.push_back(r);
                ok = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_chk(input req_t r);
        bit ok;
        push(r, 300, ok);
        if (!ok) chk($sformatf("push_timeout_tag%0d", r.tag), 72'(ok), 72'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 72'(sb_q.size()), 72'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        req_t r;
        bit   ok;
        int   seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", 72'({out_valid, out_result, out_nx, out_err, out_tag, out_op,
                               mul_start, div_start, occupancy}), 72'd0);
        chk("reset_eng", 72'({eng_a, eng_b, eng_frm}), 72'd0);
        rst_n = 1'b1;
        chk("ready_after_reset", 72'(in_ready), 72'd1);
        @(negedge clk);

        // Single multiply with minimum latency
        out_ready = 1'b1;
        r = mk(1'b0, 4'd3, 1, 1'b0);
        r.a = 32'h3FC0_0000; r.b = 32'h4000_0000; r.res = 32'h4040_0000; r.nx = 1'b0;
        in_valid = 1'b1; in_op = r.op; in_frm = r.frm; in_a = r.a; in_b = r.b; in_tag = r.tag;
        chk("t1_ready", 72'(in_ready), 72'd1);
        sb_q.push_back(r); eng_q.push_back(r);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_k0", 72'({mul_start, div_start, out_valid}), 72'd0);
        @(negedge clk);
        chk("t1_k1_start", 72'({mul_start, div_start}), 72'd2);
        @(negedge clk);
        chk("t1_k2", 72'({mul_start, div_start, out_valid}), 72'd0);
        @(negedge clk);
        chk("t1_k3_valid", 72'(out_valid), 72'd1);
        drain(50);

        // Backpressure fill: one in flight plus DEPTH queued
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push(mk(1'($urandom), TAGW'(t), 1, 1'b0), 20, ok);
            chk($sformatf("bp_push%0d", t), 72'(ok), 72'd1);
        end
        repeat (3) @(negedge clk);
        chk("bp_full", 72'({occupancy, in_ready}), 72'({OCCW'(DEPTH), 1'b0}));
        push(mk(1'b0, 4'd5, 1, 1'b0), 8, ok);
        chk("bp_sixth_blocked", 72'(ok), 72'd0);
        out_ready = 1'b1;
        drain(200);

        // Timeout, then a normal request
        push_chk(mk(1'b1, 4'd6, 0, 1'b1));
        push_chk(mk(1'b0, 4'd7, 2, 1'b0));
        drain(200);

        // Done coincident with timeout, stray completions from the idle engine
        stray_en = 1'b1;
        push_chk(mk(1'b1, 4'd8, int'(TIMEOUT), 1'b0));
        push_chk(mk(1'b0, 4'd9, 3, 1'b0));
        push_chk(mk(1'b1, 4'd10, 4, 1'b0));
        drain(200);
        stray_en = 1'b0;
        @(negedge clk);

        // Flush during WAIT with three queued
        push_chk(mk(1'b1, 4'd10, 12, 1'b0));
        repeat (3) @(negedge clk);
        for (int t = 11; t < 14; t++) push_chk(mk(1'b0, TAGW'(t), 1, 1'b0));
        chk("flush_pre_occ", 72'(occupancy), 72'd3);
        flush = 1'b1;
        sb_q.delete();
        eng_q.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("flush_post", 72'({occupancy, out_valid}), 72'd0);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid || mul_start || div_start) seen++;
        end
        chk("flush_quiet", 72'(seen), 72'd0);
        push_chk(mk(1'b0, 4'd14, 2, 1'b0));
        drain(100);

        // Reset while a response is pending
        out_ready = 1'b0;
        push_chk(mk(1'b0, 4'd15, 1, 1'b0));
        seen = 0;
        while (!out_valid && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        chk("resp_reached", 72'(out_valid), 72'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 72'({out_valid, out_result, out_nx, out_err, out_tag, out_op,
                                     mul_start, div_start, occupancy}), 72'd0);
        chk("async_reset_eng", 72'({eng_a, eng_b, eng_frm}), 72'd0);
        sb_q.delete();
        eng_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_after_rerelease", 72'(in_ready), 72'd1);
        @(negedge clk);

        // Random traffic with random backpressure, latencies around the timeout edge
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int sel;
            int lat;
            sel = int'($urandom_range(0, 9));
            lat = (sel < 7) ? int'($urandom_range(1, 6)) :
                  (sel == 7) ? int'(TIMEOUT) : int'(TIMEOUT) + 1;
            push_chk(mk(1'($urandom), TAGW'(i), lat, (sel == 9)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain(3000);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
